cmac_fixed_pipe: RTL and testbench
==================================

Name: cmac_fixed_pipe

Overview:
- Pipelined signed fixed-point complex multiply-accumulate for the convolution datapath.
- Per accepted beat, computes a*b (complex) and accumulates into a wide accumulator. On the last beat of a burst, emits the rounded result at QI+QF width, with a selectable saturate or wrap mode.
- Sits between the kernel/sample fetch logic and the result writer. Valid/ready on both sides.

Parameters:
- QI, 3, integer bits (including sign) of inputs and outputs.
- QF, 3, fractional bits of inputs and outputs.
- GUARD, 4, extra accumulator MSBs; guarantees no internal overflow for up to 2^GUARD beats per burst.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  beat is the last of an accumulation burst.
- a_re, a_im, b_re, b_im  in  QI+QF each  signed Q(QI.QF) operands.
- mode_sat  in  1  1 = saturate output, 0 = wrap; sampled with the in_last beat.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- y_re, y_im  out  QI+QF each  signed Q(QI.QF) result.
- overflow  out  1  result did not fit in QI+QF (set in both modes).
- sat_flag  out  1  result was clamped (mode_sat=1 only).

Behaviour:
- Widths: W=QI+QF; product P=2W; sum S=2W+1; accumulator A=2W+1+GUARD. All arithmetic is signed and sign-extended; no intermediate wraps for up to 2^GUARD beats per burst.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall. When stall is high, every pipeline register holds.
- S1 (cycle after accept): register pr=a_re*b_re, pi_=a_im*b_im, q1=a_re*b_im, q2=a_im*b_re, plus valid, last and mode.
- S2: re_sum=pr-pi_, im_sum=q1+q2, sign-extended to A.
  - If the previous S2 beat was last, or after reset: acc <= sum.
  - Otherwise: acc <= acc + sum.
- S3, when the S2 beat was last:
  - Round half-up: r = (acc + 2^(QF-1)) >>> QF (arithmetic shift).
  - Fit: r fits if r is within [-2^(W-1), 2^(W-1)-1].
  - overflow = not fit, for either component.
  - mode_sat=1: clamp each component to its bound; sat_flag = overflow.
  - mode_sat=0: take low W bits; sat_flag = 0.
  - out_valid <= 1.
- out_valid stays high, and y_re/y_im/overflow/sat_flag stay stable, until out_ready is seen high on a clock edge. It then drops, unless a new result is loaded on the same edge, in which case it stays high with the new data.
- Latency: the in_last beat accepted at edge N gives out_valid high after edge N+3. Throughput: 1 beat per cycle with no stall.
- A burst of a single beat (in_last=1 on the first beat) is legal.
- Gaps (in_valid=0) inside a burst do not disturb acc.
- in_valid while in_ready=0 is ignored; the source must hold the beat.
- Reset (async, any time, including mid-burst or while out_valid is held): all valid bits, acc, y_re, y_im, overflow and sat_flag go to 0. in_ready=1 once reset is released. A partial burst is discarded.
- Accumulator overflow beyond 2^GUARD beats is undefined and is not flagged.

Decomposition:
- Shared package cmac_pkg:
  - Width helper functions for W, P, S and A.
  - Localparam for the rounding constant.
  - A sat/wrap mode enum, reused by the FIR controller.
- One natural sub-module, fixed_round_sat: combinational rounding plus saturate/wrap of one A-bit component to W bits, with fit/clamp flags. Instantiated twice, for the re and im components.

Test Plan:
- QI=QF=3; single beat a=8+j8, b=8+j8 (1+j)^2, mode_sat=1 -> after 3 cycles y_re=0, y_im=16, overflow=0.
- Burst of 3 beats, each a=8, b=8, imaginary parts 0 -> one result y_re=24 (3.0), y_im=0. out_valid pulses exactly once.
- Single beat a_re=b_re=31, imaginary parts 0 (product 961):
  - mode_sat=1 -> y_re=31, overflow=1, sat_flag=1.
  - mode_sat=0 -> y_re=-8 (6'b111000), overflow=1, sat_flag=0.
- Single beat a_re=b_re=-32 -> y_re=31, sat_flag=1. Then a burst of 4 beats of 8*8 with mode_sat=1 -> y_re=31 (4.0 clamps), overflow=1.
- Hold out_ready=0 for 5 cycles with out_valid high and beats pending:
  - in_ready=0 and outputs stable throughout.
  - Releasing out_ready yields the queued results in order, with no loss or duplication.
- Assert rst_n low mid-burst, after 2 of 3 beats, then send a fresh 1-beat burst a=8, b=8 -> outputs 0 during reset, then y_re=8 with no residue from the discarded burst.

Source files
------------

// File: rtl/cmac_pkg.sv
// Shared widths, defaults and rounding/saturation helpers for the complex MAC
// datapath and the FIR controller built on top of it.
package cmac_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } sat_mode_e;

  localparam int CMAC_QI_DEF    = 3;
  localparam int CMAC_QF_DEF    = 3;
  localparam int CMAC_GUARD_DEF = 4;
  // Half-LSB of the output grid at the default format.
  localparam int CMAC_RND_DEF   = 1 << (CMAC_QF_DEF - 1);

  function automatic int cmac_w(input int qi, input int qf);
    return qi + qf;
  endfunction

  function automatic int cmac_p(input int qi, input int qf);
    return 2 * cmac_w(qi, qf);
  endfunction

  function automatic int cmac_s(input int qi, input int qf);
    return cmac_p(qi, qf) + 1;
  endfunction

  function automatic int cmac_a(input int qi, input int qf, input int guard);
    return cmac_s(qi, qf) + guard;
  endfunction

  function automatic int cmac_round_const(input int qf);
    return 1 << (qf - 1);
  endfunction

endpackage

// File: rtl/cmac_fixed_pipe_round_sat.sv
// Round-half-up of one accumulator component onto the Q(QI.QF) output grid,
// then clamp or wrap to W bits, reporting whether the value fit.
module fixed_round_sat
  import cmac_pkg::*;
#(
  parameter int QF = CMAC_QF_DEF,
  parameter int W  = 6,
  parameter int A  = 17
) (
  input  logic [A-1:0]        acc,
  input  sat_mode_e           mode,
  output logic signed [W-1:0] y,
  output logic                ovf,
  output logic                clamp
);
  localparam int R = A + 1 - QF;
  localparam logic signed [A:0]   RND_C = (A+1)'(cmac_round_const(QF));
  localparam logic signed [R-1:0] MAXV  = R'((1 << (W - 1)) - 1);
  localparam logic signed [R-1:0] MINV  = -MAXV - R'(1);
  localparam logic [W-1:0]        YMAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]        YMIN  = {1'b1, {(W-1){1'b0}}};

  logic signed [A:0]   biased;
  logic signed [R-1:0] r;
  logic                fit;

  always_comb begin
    // One extra MSB so the rounding add itself can never wrap.
    biased = $signed({acc[A-1], acc}) + RND_C;
    r      = biased[A:QF];
    fit    = (r >= MINV) && (r <= MAXV);
    ovf    = ~fit;
    clamp  = (mode == MODE_SAT) && ~fit;
    y      = r[W-1:0];
    if (clamp) y = r[R-1] ? YMIN : YMAX;
  end

endmodule

// File: rtl/cmac_fixed_pipe.sv
// Pipelined signed complex multiply-accumulate: products, sums, accumulate,
// then rounded/saturated result held until the writer takes it.
module cmac_fixed_pipe
  import cmac_pkg::*;
#(
  parameter int QI    = CMAC_QI_DEF,
  parameter int QF    = CMAC_QF_DEF,
  parameter int GUARD = CMAC_GUARD_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_last,
  input  logic signed [cmac_w(QI,QF)-1:0] a_re,
  input  logic signed [cmac_w(QI,QF)-1:0] a_im,
  input  logic signed [cmac_w(QI,QF)-1:0] b_re,
  input  logic signed [cmac_w(QI,QF)-1:0] b_im,
  input  logic                            mode_sat,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [cmac_w(QI,QF)-1:0] y_re,
  output logic signed [cmac_w(QI,QF)-1:0] y_im,
  output logic                            overflow,
  output logic                            sat_flag
);
  localparam int W = cmac_w(QI, QF);
  localparam int P = cmac_p(QI, QF);
  localparam int S = cmac_s(QI, QF);
  localparam int A = cmac_a(QI, QF, GUARD);

  logic signed [P-1:0] pr_q, pr_d, pi_q, pi_d, q1_q, q1_d, q2_q, q2_d;
  logic [1:0]          vld_pipe_q, vld_pipe_d;
  logic                last1_q, last1_d, last2_q, last2_d;
  sat_mode_e           mode1_q, mode1_d, mode2_q, mode2_d, mode3_q, mode3_d;
  logic [1:0][S-1:0]   sum_q, sum_d;
  logic [1:0][A-1:0]   acc_q, acc_d, acc_ext;
  logic                first_q, first_d, done_q, done_d;
  logic [1:0][W-1:0]   y_q, y_d, y_rnd;
  logic [1:0]          ovf_rnd, clamp_rnd;
  logic                out_valid_q, out_valid_d, ovf_q, ovf_d, sat_q, sat_d;
  logic                stall;

  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;
  assign y_re      = y_q[0];
  assign y_im      = y_q[1];
  assign overflow  = ovf_q;
  assign sat_flag  = sat_q;

  // Component 0 is real, 1 is imaginary throughout.
  for (genvar c = 0; c < 2; c++) begin : g_cmp
    assign acc_ext[c] = {{(A-S){sum_q[c][S-1]}}, sum_q[c]};
    fixed_round_sat #(.QF(QF), .W(W), .A(A)) u_rnd (
      .acc   (acc_q[c]),
      .mode  (mode3_q),
      .y     (y_rnd[c]),
      .ovf   (ovf_rnd[c]),
      .clamp (clamp_rnd[c])
    );
  end

  always_comb begin
    pr_d = pr_q; pi_d = pi_q; q1_d = q1_q; q2_d = q2_q;
    vld_pipe_d = vld_pipe_q;
    last1_d = last1_q; last2_d = last2_q;
    mode1_d = mode1_q; mode2_d = mode2_q; mode3_d = mode3_q;
    sum_d = sum_q; acc_d = acc_q;
    first_d = first_q; done_d = done_q;
    out_valid_d = out_valid_q; y_d = y_q; ovf_d = ovf_q; sat_d = sat_q;
    if (!stall) begin
      vld_pipe_d = {vld_pipe_q[0], in_valid};
      if (in_valid) begin
        pr_d    = a_re * b_re;
        pi_d    = a_im * b_im;
        q1_d    = a_re * b_im;
        q2_d    = a_im * b_re;
        last1_d = in_last;
        mode1_d = sat_mode_e'(mode_sat);
      end
      if (vld_pipe_q[0]) begin
        sum_d[0] = {pr_q[P-1], pr_q} - {pi_q[P-1], pi_q};
        sum_d[1] = {q1_q[P-1], q1_q} + {q2_q[P-1], q2_q};
        last2_d  = last1_q;
        mode2_d  = mode1_q;
      end
      done_d = vld_pipe_q[1] & last2_q;
      if (vld_pipe_q[1]) begin
        for (int c = 0; c < 2; c++)
          acc_d[c] = first_q ? acc_ext[c] : acc_q[c] + acc_ext[c];
        first_d = last2_q;
        mode3_d = mode2_q;
      end
      // Not stalled means any held result is being taken this edge.
      out_valid_d = done_q;
      if (done_q) begin
        y_d   = y_rnd;
        ovf_d = |ovf_rnd;
        sat_d = |clamp_rnd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_q <= '0; pi_q <= '0; q1_q <= '0; q2_q <= '0;
      vld_pipe_q <= '0;
      last1_q <= 1'b0; last2_q <= 1'b0;
      mode1_q <= MODE_WRAP; mode2_q <= MODE_WRAP; mode3_q <= MODE_WRAP;
      sum_q <= '0; acc_q <= '0;
      first_q <= 1'b1; done_q <= 1'b0;
      out_valid_q <= 1'b0; y_q <= '0; ovf_q <= 1'b0; sat_q <= 1'b0;
    end else begin
      pr_q <= pr_d; pi_q <= pi_d; q1_q <= q1_d; q2_q <= q2_d;
      vld_pipe_q <= vld_pipe_d;
      last1_q <= last1_d; last2_q <= last2_d;
      mode1_q <= mode1_d; mode2_q <= mode2_d; mode3_q <= mode3_d;
      sum_q <= sum_d; acc_q <= acc_d;
      first_q <= first_d; done_q <= done_d;
      out_valid_q <= out_valid_d; y_q <= y_d; ovf_q <= ovf_d; sat_q <= sat_d;
    end
  end

endmodule

// File: tb/tb_cmac_fixed_pipe.sv
// Directed bench for cmac_fixed_pipe at Q3.3 with hand-computed expectations.
module tb_cmac_fixed_pipe;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0, in_last = 1'b0, mode_sat = 1'b0;
  logic              out_ready = 1'b1;
  logic signed [5:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic              in_ready, out_valid, overflow, sat_flag;
  logic signed [5:0] y_re, y_im;
  int                cmp_cnt = 0;
  int                err_cnt = 0;

  cmac_fixed_pipe #(.QI(3), .QF(3), .GUARD(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .mode_sat(mode_sat), .out_valid(out_valid), .out_ready(out_ready),
    .y_re(y_re), .y_im(y_im), .overflow(overflow), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic signed [5:0] ar, ai, br, bi,
                      input logic last, input logic md);
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    in_last = last; mode_sat = md; in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk(tag, out_valid, 1);
  endtask

  initial begin
    int pulses;
    int got[$];
    logic signed [31:0] seen;

    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_y_re", y_re, 0);
    chk("rst_y_im", y_im, 0);
    rst_n = 1'b1;
    tick();

    // (1+j)^2 = 2j, with exact 3-edge latency
    send(8, 8, 8, 8, 1, 1);
    chk("lat_n0", out_valid, 0);
    tick(); tick();
    chk("lat_n2", out_valid, 0);
    tick();
    chk("lat_n3", out_valid, 1);
    chk("cplx_y_re", y_re, 0);
    chk("cplx_y_im", y_im, 16);
    chk("cplx_ovf", overflow, 0);
    tick();

    // 3-beat burst of 1.0*1.0 -> 3.0, single result pulse
    send(8, 0, 8, 0, 0, 1);
    send(8, 0, 8, 0, 0, 1);
    send(8, 0, 8, 0, 1, 1);
    pulses = 0; seen = -99;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin pulses++; seen = y_re; end
      tick();
    end
    chk("burst3_pulses", pulses, 1);
    chk("burst3_y_re", seen, 24);

    // 961/8 rounds to 120: saturate, then wrap
    send(31, 0, 31, 0, 1, 1);
    wait_out("sat_valid");
    chk("sat_y_re", y_re, 31);
    chk("sat_ovf", overflow, 1);
    chk("sat_flag", sat_flag, 1);
    tick();
    send(31, 0, 31, 0, 1, 0);
    wait_out("wrap_valid");
    chk("wrap_y_re", y_re, -8);
    chk("wrap_ovf", overflow, 1);
    chk("wrap_flag", sat_flag, 0);
    tick();

    // (-4)*(-4)=16 clamps; 4-beat burst of 1.0 reaching 4.0 clamps too
    send(-32, 0, -32, 0, 1, 1);
    wait_out("neg_valid");
    chk("neg_y_re", y_re, 31);
    chk("neg_flag", sat_flag, 1);
    tick();
    for (int i = 0; i < 4; i++) send(8, 0, 8, 0, (i == 3), 1);
    wait_out("four_valid");
    chk("four_y_re", y_re, 31);
    chk("four_ovf", overflow, 1);
    chk("four_flag", sat_flag, 1);
    tick();

    // Backpressure: three queued results plus one held input beat
    out_ready = 1'b0;
    send(8, 0, 8, 0, 1, 1);
    send(16, 0, 8, 0, 1, 1);
    send(24, 0, 8, 0, 1, 1);
    wait_out("stall_valid");
    chk("stall_first", y_re, 8);
    a_re = -8; a_im = 0; b_re = 8; b_im = 0; in_last = 1'b1; mode_sat = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_y_re", y_re, 8);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) got.push_back(int'(y_re));
      tick();
    end
    chk("drain_count", got.size(), 3);
    chk("drain_0", got.size() > 0 ? got[0] : 999, 16);
    chk("drain_1", got.size() > 1 ? got[1] : 999, 24);
    chk("drain_2", got.size() > 2 ? got[2] : 999, -8);

    // Reset with a held result and a partial burst in flight
    out_ready = 1'b0;
    send(31, 0, 31, 0, 1, 1);
    send(8, 0, 8, 0, 0, 1);
    send(8, 0, 8, 0, 0, 1);
    wait_out("prerst_valid");
    chk("prerst_y_re", y_re, 31);
    rst_n = 1'b0;
    #2;
    chk("inrst_out_valid", out_valid, 0);
    chk("inrst_y_re", y_re, 0);
    chk("inrst_ovf", overflow, 0);
    chk("inrst_sat", sat_flag, 0);
    chk("inrst_in_ready", in_ready, 1);
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send(8, 0, 8, 0, 1, 1);
    wait_out("postrst_valid");
    chk("postrst_y_re", y_re, 8);
    chk("postrst_y_im", y_im, 0);
    chk("postrst_ovf", overflow, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
